snoop_responder: RTL
====================

Name: snoop_responder

Overview:
- Listening ("escuta") side of the snooping bus for one processor's private cache.
- Accepts bus transactions broadcast by other processors and looks up its own line array. It updates the line's coherence state (MSI).
- When it holds the line Modified, it flushes the dirty data to memory before acknowledging.
- One instance per processor; it sits between the shared snoop bus and the cache line storage.

Parameters:
- NUM_LINES, 4, number of direct-mapped cache lines (power of two)
- INDEX_W, 2, log2(NUM_LINES)
- TAG_W, 3, tag bits per line
- DATA_W, 4, data bits per line
- PROC_ID, 0, 2-bit id of the owning processor

Ports:
- clock  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- bus_valid  in  1  snoop request present
- bus_ready  out  1  responder can accept a request
- bus_cmd  in  2  00 BUS_RD, 01 BUS_RDX, 10 BUS_UPGR, 11 reserved
- bus_addr  in  TAG_W+INDEX_W  {tag,index}
- bus_src  in  2  id of the requesting processor
- snoop_done  out  1  one-cycle pulse, response valid
- snoop_hit  out  1  line present (state != I) with tag match
- snoop_dirty  out  1  line was M; snoop_data is valid
- snoop_data  out  DATA_W  line data supplied to the requester
- snoop_err  out  1  protocol violation (UPGR hit on M)
- wb_valid  out  1  write-back request to memory
- wb_ready  in  1  memory accepts the write-back
- wb_addr  out  TAG_W+INDEX_W  write-back address
- wb_data  out  DATA_W  write-back data
- fill_valid  in  1  local controller writes a line
- fill_ready  out  1  fill accepted this cycle
- fill_index  in  INDEX_W  line written
- fill_tag  in  TAG_W  tag written
- fill_data  in  DATA_W  data written
- fill_state  in  2  state written
- rd_index  in  INDEX_W  debug read index
- rd_state  out  2  combinational state of line rd_index
- rd_tag  out  TAG_W  combinational tag of line rd_index
- rd_data  out  DATA_W  combinational data of line rd_index

Behaviour:
- Line state encoding: I=00, S=01, M=10, 11=E; 11 is treated as I unless the optional feature is enabled.
- Reset (asynchronous, immediate):
  - all lines I, tag 0, data 0; FSM to IDLE;
  - snoop_done, snoop_hit, snoop_dirty, snoop_err, wb_valid all 0; snoop_data, wb_addr, wb_data all 0;
  - a flush in progress is abandoned and wb_valid drops at once.
- FSM states: IDLE, LOOKUP, FLUSH, RESP.
- IDLE:
  - bus_ready=1. A request is accepted when bus_valid&&bus_ready; the address, cmd and src are registered and the FSM goes to LOOKUP.
  - fill_ready=1 only in IDLE when no bus request is accepted in the same cycle (bus wins). An accepted fill writes tag, data and state at the clock edge.
- LOOKUP (1 cycle): hit = (state!=I) && tag match.
  - bus_src==PROC_ID: no state change, hit forced 0, go to RESP.
  - Hit, state M, cmd RD or RDX: go to FLUSH.
  - Otherwise apply the state update and go to RESP.
- FLUSH:
  - wb_valid=1, with wb_addr and wb_data held stable until wb_ready is sampled 1.
  - Then apply the state update and go to RESP; snoop_dirty=1, snoop_data=line data.
- RESP: snoop_done=1 for exactly one cycle, then IDLE. snoop_hit, snoop_dirty, snoop_data and snoop_err are valid only while snoop_done=1 and are 0 otherwise.
- State updates (hit only; a miss never changes state):
  - RD: M->S, S->S.
  - RDX: S or M ->I.
  - UPGR: S->I. M->I with snoop_err=1 and no flush.
  - Reserved cmd: no change, hit reported normally.
- Latency:
  - Without flush: accept at cycle T, snoop_done at T+2.
  - With flush: wb_valid from T+2; snoop_done in the cycle after the wb_ready handshake. Minimum is T+3 with wb_ready already high.
- Back-to-back requests: bus_ready returns to 1 in the cycle after snoop_done.

Optional Feature:
- SNOOP_MESI_EN defined:
  - state 11 is Exclusive;
  - E hit on RD ->S with no flush, snoop_hit=1, snoop_dirty=0;
  - E hit on RDX or UPGR ->I, no error.
- Not defined: state 11 is treated as I and never reports a hit; fill_state 11 is stored as I.

Test Plan:
- Reset, then fill index 1 tag 3'b101 data 4'hA state M; BUS_RD addr {101,01} src 1 -> wb_valid with wb_addr 5'b10101, wb_data 4'hA; after wb_ready, snoop_done with hit=1, dirty=1, data=4'hA; rd_state(1)=S.
- Line 2 state S; BUS_RDX to a matching address with src 2 -> snoop_done at T+2, hit=1, dirty=0, no wb_valid; rd_state(2)=I.
- BUS_RD with a tag mismatch on a valid line -> hit=0, state unchanged; request with bus_src==PROC_ID on a hit line -> hit=0, state unchanged.
- Line in M, BUS_UPGR hit -> snoop_err=1, line I, wb_valid never asserted.
- Hold wb_ready=0 for 5 cycles during FLUSH with fill_valid=1 -> wb signals stable and fill_ready=0 throughout. Assert reset_n=0 mid-FLUSH -> wb_valid 0 immediately and all lines I.
- With SNOOP_MESI_EN: line E, BUS_RD hit -> hit=1, dirty=0, state S, no flush. Without the macro: fill_state 11, then BUS_RD -> hit=0.

Source files
------------

// File: rtl/snoop_responder_if.sv
// Snoop bus bundle between requesters and one responder.
// Carries the request handshake (bus_*) and the one-cycle response (snoop_*).
interface snoop_responder_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
);
  logic              bus_valid;
  logic              bus_ready;
  logic [1:0]        bus_cmd;
  logic [ADDR_W-1:0] bus_addr;
  logic [1:0]        bus_src;
  logic              snoop_done;
  logic              snoop_hit;
  logic              snoop_dirty;
  logic [DATA_W-1:0] snoop_data;
  logic              snoop_err;

  modport master (
    output bus_valid,
    output bus_cmd,
    output bus_addr,
    output bus_src,
    input  bus_ready,
    input  snoop_done,
    input  snoop_hit,
    input  snoop_dirty,
    input  snoop_data,
    input  snoop_err
  );

  modport slave (
    input  bus_valid,
    input  bus_cmd,
    input  bus_addr,
    input  bus_src,
    output bus_ready,
    output snoop_done,
    output snoop_hit,
    output snoop_dirty,
    output snoop_data,
    output snoop_err
  );
endinterface

// File: rtl/snoop_responder.sv
// MSI snoop responder for one private direct-mapped cache; flushes M lines.
// Ports: clock/reset_n, bus (snoop if), wb_* write-back, fill_* line write,
// rd_* debug read. Define SNOOP_MESI_EN to treat line state 11 as Exclusive.
module snoop_responder #(
  parameter int         NUM_LINES = 4,
  parameter int         INDEX_W   = 2,
  parameter int         TAG_W     = 3,
  parameter int         DATA_W    = 4,
  parameter logic [1:0] PROC_ID   = 2'd0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  snoop_responder_if.slave         bus,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [TAG_W+INDEX_W-1:0] wb_addr,
  output logic [DATA_W-1:0]        wb_data,
  input  logic                     fill_valid,
  output logic                     fill_ready,
  input  logic [INDEX_W-1:0]       fill_index,
  input  logic [TAG_W-1:0]         fill_tag,
  input  logic [DATA_W-1:0]        fill_data,
  input  logic [1:0]               fill_state,
  input  logic [INDEX_W-1:0]       rd_index,
  output logic [1:0]               rd_state,
  output logic [TAG_W-1:0]         rd_tag,
  output logic [DATA_W-1:0]        rd_data
);

  localparam int ADDR_W = TAG_W + INDEX_W;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    FLUSH,
    RESP
  } fsm_t;

  fsm_t fsm_q, fsm_d;

  logic [1:0]        st_q   [NUM_LINES];
  logic [TAG_W-1:0]  tag_q  [NUM_LINES];
  logic [DATA_W-1:0] data_q [NUM_LINES];

  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_cmd;
  logic [1:0]        req_src;

  logic              resp_hit;
  logic              resp_dirty;
  logic              resp_err;
  logic [DATA_W-1:0] resp_data;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [1:0]         cur_st;
  logic [1:0]         upd_st;
  logic               lk_hit;
  logic               cmd_rd;
  logic               cmd_rdx;
  logic               cmd_upgr;
  logic               cmd_rsv;
  logic               accept;
  logic               fill_we;
  logic               line_we;

  // Without MESI support state 11 is never valid.
  function automatic logic [1:0] norm(input logic [1:0] s);
`ifdef SNOOP_MESI_EN
    return s;
`else
    return (s == 2'b11) ? ST_I : s;
`endif
  endfunction

  assign idx = req_addr[INDEX_W-1:0];
  assign tag = req_addr[ADDR_W-1:INDEX_W];

  assign cur_st = norm(st_q[idx]);

  assign cmd_rd   = (req_cmd == 2'b00);
  assign cmd_rdx  = (req_cmd == 2'b01);
  assign cmd_upgr = (req_cmd == 2'b10);
  assign cmd_rsv  = (req_cmd == 2'b11);

  // Own requests echoed on the bus never hit.
  assign lk_hit = (cur_st != ST_I)
               && (tag_q[idx] == tag)
               && (req_src != PROC_ID);

  always_comb begin
    upd_st = cur_st;
    unique case (1'b1)
      cmd_rd:   upd_st = ST_S;
      cmd_rdx:  upd_st = ST_I;
      cmd_upgr: upd_st = ST_I;
      cmd_rsv:  upd_st = cur_st;
      default:  upd_st = cur_st;
    endcase
  end

  always_comb begin
    fsm_d      = fsm_q;
    line_we    = 1'b0;
    bus.bus_ready = (fsm_q == IDLE);
    accept     = bus.bus_valid && bus.bus_ready;
    fill_ready = (fsm_q == IDLE) && !accept;
    fill_we    = fill_valid && fill_ready;
    unique case (fsm_q)
      IDLE: begin
        if (accept) fsm_d = LOOKUP;
      end
      LOOKUP: begin
        if (lk_hit && cur_st == ST_M
            && (cmd_rd || cmd_rdx)) begin
          fsm_d = FLUSH;
        end else begin
          line_we = lk_hit;
          fsm_d   = RESP;
        end
      end
      FLUSH: begin
        if (wb_ready) begin
          line_we = 1'b1;
          fsm_d   = RESP;
        end
      end
      RESP: begin
        fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) fsm_q <= IDLE;
    else          fsm_q <= fsm_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_addr <= '0;
      req_cmd  <= '0;
      req_src  <= '0;
    end else if (accept) begin
      req_addr <= bus.bus_addr;
      req_cmd  <= bus.bus_cmd;
      req_src  <= bus.bus_src;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        st_q[i]   <= ST_I;
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (fill_we) begin
      st_q[fill_index]   <= norm(fill_state);
      tag_q[fill_index]  <= fill_tag;
      data_q[fill_index] <= fill_data;
    end else if (line_we) begin
      st_q[idx] <= upd_st;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resp_hit   <= 1'b0;
      resp_dirty <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
    end else begin
      unique case (fsm_q)
        LOOKUP: begin
          resp_hit   <= lk_hit;
          resp_err   <= lk_hit && cmd_upgr
                     && (cur_st == ST_M);
          resp_dirty <= 1'b0;
          resp_data  <= '0;
        end
        FLUSH: begin
          if (wb_ready) begin
            resp_dirty <= 1'b1;
            resp_data  <= data_q[idx];
          end
        end
        default: ;
      endcase
    end
  end

  // Request regs and the line are frozen during FLUSH, so wb_* hold stable.
  assign wb_valid = (fsm_q == FLUSH);
  assign wb_addr  = wb_valid ? req_addr : '0;
  assign wb_data  = wb_valid ? data_q[idx] : '0;

  assign bus.snoop_done  = (fsm_q == RESP);
  assign bus.snoop_hit   = bus.snoop_done && resp_hit;
  assign bus.snoop_dirty = bus.snoop_done && resp_dirty;
  assign bus.snoop_err   = bus.snoop_done && resp_err;
  assign bus.snoop_data  = bus.snoop_done ? resp_data : '0;

  assign rd_state = st_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule
